// File: rtl/speed_tick_ctrl_if.sv
// Control/status bundle for the game-speed tick controller.
// The host side drives run and the speed requests. The controller side
// returns the current level, the tick pulse, the square wave and the ramp-busy flag.
interface speed_tick_if;
    logic       run;
    logic       accel_req;
    logic       brake_req;
    logic [2:0] level;
    logic       tick;
    logic       y;
    logic       busy;

    modport master (
        output run, accel_req, brake_req,
        input  level, tick, y, busy
    );

    modport slave (
        input  run, accel_req, brake_req,
        output level, tick, y, busy
    );
endinterface

// File: rtl/speed_tick_ctrl.sv
// Speed-level-scheduled divider for the game timing chain.
// Each speed level selects the divider period. Held accel/brake requests
// move the level one step after they persist for RAMP_TICKS ticks.
// A level change and its period change take effect only at a wrap, so the
// outputs never glitch. All state updates on the falling edge of clock_in.
module speed_tick_ctrl #(
    parameter logic [26:0] BASE_PERIOD = 27'd330000,
    parameter logic [26:0] STEP        = 27'd30000,
    parameter logic [2:0]  MAX_LEVEL   = 3'd7,
    parameter logic [7:0]  RAMP_TICKS  = 8'd16
) (
    input  logic        clock_in,
    input  logic        reset_n,
    speed_tick_if.slave bus
);

    // The fastest level must still leave a period of at least two clocks.
    if (BASE_PERIOD < 27'(MAX_LEVEL) * STEP + 27'd2) begin : g_bad_period
        $error("speed_tick_ctrl: BASE_PERIOD too small for MAX_LEVEL*STEP + 2");
    end
    if (RAMP_TICKS == 8'd0) begin : g_bad_ramp
        $error("speed_tick_ctrl: RAMP_TICKS must be >= 1");
    end

    typedef enum logic {PAUSE = 1'b0, RUN = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [26:0] z, period_q, period_nx;
    logic [7:0]  ramp_cnt, ramp_nx;
    logic [2:0]  level_q, level_nx;
    logic        tick_q, y_q;
    logic        wrap;
    logic        req;

    assign wrap = (z == period_q - 27'd1);
    assign req  = bus.brake_req | bus.accel_req;

    // Run/pause state register.
    always_ff @(negedge clock_in or negedge reset_n) begin
        if (!reset_n) state_q <= PAUSE;
        else          state_q <= state_d;
    end

    // Next state follows run on every edge. Counting on this edge uses the
    // state being entered, so a pause freezes z on the same edge as run drops.
    always_comb begin
        state_d = state_q;
        case (state_q)
            PAUSE:   if (bus.run)  state_d = RUN;
            RUN:     if (!bus.run) state_d = PAUSE;
            default: state_d = PAUSE;
        endcase
    end

    // Ramp scheduler and the next level. Brake wins over accel, and both
    // requests share one counter, so changing direction keeps progress.
    always_comb begin
        level_nx = level_q;
        ramp_nx  = 8'd0;
        if (req) begin
            if (ramp_cnt < RAMP_TICKS - 8'd1) begin
                ramp_nx = ramp_cnt + 8'd1;
            end else if (bus.brake_req) begin
                if (level_q != 3'd0) level_nx = level_q - 3'd1;
            end else begin
                if (level_q != MAX_LEVEL) level_nx = level_q + 3'd1;
            end
        end
    end

    assign period_nx = BASE_PERIOD - 27'(level_nx) * STEP;

    // Divider, outputs and wrap-time level/period commit.
    always_ff @(negedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            z        <= '0;
            period_q <= BASE_PERIOD;
            level_q  <= '0;
            ramp_cnt <= '0;
            tick_q   <= 1'b0;
            y_q      <= 1'b0;
        end else if (state_d == RUN) begin
            y_q    <= (z < (period_q >> 1));
            tick_q <= wrap;
            if (wrap) begin
                z        <= '0;
                period_q <= period_nx;
                level_q  <= level_nx;
                ramp_cnt <= ramp_nx;
            end else begin
                z <= z + 27'd1;
            end
        end else begin
            tick_q <= 1'b0;
        end
    end

    assign bus.level = level_q;
    assign bus.tick  = tick_q;
    assign bus.y     = y_q;
    assign bus.busy  = (ramp_cnt != 8'd0);

endmodule

// File: tb/tb_speed_tick_ctrl.sv
// Bench for speed_tick_ctrl with small parameters (periods 10/8/6/4).
// Directed scenarios plus a randomized phase. Each cycle is checked
// against a period/level reference model.
module tb_speed_tick_ctrl;
    localparam int B  = 10;
    localparam int S  = 2;
    localparam int ML = 3;
    localparam int RT = 2;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;

    // Reference model state.
    int   m_pos, m_per, m_lvl, m_ramp;
    logic m_tick, m_y;

    speed_tick_if bus ();

    speed_tick_ctrl #(
        .BASE_PERIOD(27'd10), .STEP(27'd2), .MAX_LEVEL(3'd3), .RAMP_TICKS(8'd2)
    ) dut (
        .clock_in(clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic m_rst();
        m_pos = 0; m_per = B; m_lvl = 0; m_ramp = 0; m_tick = 0; m_y = 0;
    endtask

    // One falling edge of the reference model. Position runs through the
    // current period. At the end of a period the held request schedules
    // a level change, and the next period length follows from the level.
    task automatic m_step(input logic r, input logic a, input logic b);
        if (!r) begin
            m_tick = 0;
            return;
        end
        m_y    = (m_pos < m_per / 2);
        m_tick = (m_pos == m_per - 1);
        if (m_tick) begin
            m_pos = 0;
            if (a || b) begin
                m_ramp++;
                if (m_ramp == RT) begin
                    m_ramp = 0;
                    if (b) m_lvl = (m_lvl > 0) ? m_lvl - 1 : 0;
                    else   m_lvl = (m_lvl < ML) ? m_lvl + 1 : ML;
                end
            end else begin
                m_ramp = 0;
            end
            m_per = B - m_lvl * S;
        end else begin
            m_pos++;
        end
    endtask

    // Sample on the rising edge, check against the model, then drive the
    // inputs for the next falling edge and advance the model to match.
    task automatic cyc(input logic r, input logic a, input logic b);
        @(posedge clk);
        chk("tick",  32'(bus.tick),  32'(m_tick));
        chk("y",     32'(bus.y),     32'(m_y));
        chk("level", 32'(bus.level), 32'(m_lvl));
        chk("busy",  32'(bus.busy),  32'(m_ramp != 0));
        bus.run = r; bus.accel_req = a; bus.brake_req = b;
        m_step(r, a, b);
    endtask

    // Run until a tick is observed. n = cycles taken, hi = y-high samples.
    task automatic wait_tick(input logic r, input logic a, input logic b,
                             output int n, output int hi);
        bit seen = 0;
        n = 0; hi = 0;
        for (int i = 0; i < 200; i++) begin
            cyc(r, a, b);
            n++;
            if (bus.y === 1'b1) hi++;
            if (bus.tick === 1'b1) begin
                seen = 1;
                break;
            end
        end
        if (!seen) chk("tick_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int n, hi;
        int   gap_acc [8] = '{10, 10, 8, 8, 6, 6, 4, 4};
        int   lvl_acc [8] = '{0, 1, 1, 2, 2, 3, 3, 3};
        int   gap_brk [8] = '{4, 4, 6, 6, 8, 8, 10, 10};
        int   lvl_brk [8] = '{3, 2, 2, 1, 1, 0, 0, 0};
        logic yfrz;

        // 1. Reset and basic run.
        rst_n = 1'b0;
        bus.run = 1'b0; bus.accel_req = 1'b0; bus.brake_req = 1'b0;
        m_rst();
        repeat (3) @(posedge clk);
        chk("rst_tick",  32'(bus.tick),  32'd0);
        chk("rst_y",     32'(bus.y),     32'd0);
        chk("rst_level", 32'(bus.level), 32'd0);
        chk("rst_busy",  32'(bus.busy),  32'd0);
        rst_n = 1'b1;
        cyc(1, 0, 0);
        wait_tick(1, 0, 0, n, hi);
        chk("s1_first_gap", n, 10);
        wait_tick(1, 0, 0, n, hi);
        chk("s1_gap", n, 10);
        chk("s1_yhigh", hi, 5);
        chk("s1_level", 32'(bus.level), 32'd0);

        // 2. Accelerate to saturation.
        for (int t = 0; t < 8; t++) begin
            wait_tick(1, 1, 0, n, hi);
            chk("s2_gap",   n, gap_acc[t]);
            chk("s2_level", 32'(bus.level), lvl_acc[t]);
            chk("s2_busy",  32'(bus.busy),  (t % 2 == 0) ? 1 : 0);
        end

        // 3. Brake priority down to the floor.
        for (int t = 0; t < 8; t++) begin
            wait_tick(1, 1, 1, n, hi);
            chk("s3_gap",   n, gap_brk[t]);
            chk("s3_level", 32'(bus.level), lvl_brk[t]);
        end

        // 4. Pause at z=4 for 20 clocks, then resume.
        repeat (3) cyc(1, 0, 0);
        yfrz = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc(0, 0, 0);
            if (i == 1) yfrz = bus.y;
            if (i >= 1) chk("s4_tick_paused", 32'(bus.tick), 32'd0);
            if (i >= 2) chk("s4_y_frozen", 32'(bus.y), 32'(yfrz));
        end
        cyc(1, 0, 0);
        wait_tick(1, 0, 0, n, hi);
        chk("s4_resume_gap", n, 6);

        // 5. Request dropout restarts the ramp.
        wait_tick(1, 1, 0, n, hi);
        chk("s5_busy_a", 32'(bus.busy), 32'd1);
        wait_tick(1, 0, 0, n, hi);
        chk("s5_busy_b", 32'(bus.busy), 32'd0);
        chk("s5_level_b", 32'(bus.level), 32'd0);
        wait_tick(1, 1, 0, n, hi);
        chk("s5_level_c", 32'(bus.level), 32'd0);
        wait_tick(1, 1, 0, n, hi);
        chk("s5_level_d", 32'(bus.level), 32'd1);

        // 6. Async reset mid-ramp at level 2.
        wait_tick(1, 1, 0, n, hi);
        wait_tick(1, 1, 0, n, hi);
        wait_tick(1, 1, 0, n, hi);
        chk("s6_pre_level", 32'(bus.level), 32'd2);
        chk("s6_pre_busy",  32'(bus.busy),  32'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        bus.run = 1'b0; bus.accel_req = 1'b0; bus.brake_req = 1'b0;
        #1;
        chk("s6_async_level", 32'(bus.level), 32'd0);
        chk("s6_async_busy",  32'(bus.busy),  32'd0);
        chk("s6_async_tick",  32'(bus.tick),  32'd0);
        chk("s6_async_y",     32'(bus.y),     32'd0);
        #4 rst_n = 1'b1;
        m_rst();
        cyc(1, 0, 0);
        wait_tick(1, 0, 0, n, hi);
        chk("s6_first_gap", n, 10);
        chk("s6_level", 32'(bus.level), 32'd0);

        // Randomized segments of held run/request patterns.
        for (int seg = 0; seg < 40; seg++) begin
            logic r, a, b;
            int   len;
            r   = ($urandom % 8) != 0;
            a   = $urandom % 2;
            b   = ($urandom % 4) == 0;
            len = $urandom_range(1, 30);
            repeat (len) cyc(r, a, b);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
